// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS core definitions.
//   - ALU control codes driven to the ALU
//   - ALUOp encodings produced by the main decoder
//   - opcode / funct constants used by the decoders
//   - ID/EX stage register layout and immediate extension helper
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ID/EX pipeline register contents
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        reg_dst;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
  } ex_reg_t;

  // Logical immediates (andi/ori) are zero-extended, everything else sign-extended.
  function automatic logic [31:0] imm_extend(input logic [5:0] opcode, input logic [15:0] imm16);
    if (opcode == OP_ANDI || opcode == OP_ORI) return {16'h0000, imm16};
    return {{16{imm16[15]}}, imm16};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALU control decoder.
//   aluOp  in 2 : 00 add, 01 sub, 10 funct-driven, 11 opcode-driven
//   opcode in 6 : instruction [31:26]
//   funct  in 6 : instruction [5:0]
//   aluCtrl out 4 : ALU control code, ALU_NOP for unsupported encodings
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] aluCtrl
);

  always_comb begin
    aluCtrl = ALU_NOP;
    unique case (aluOp)
      ALUOP_ADD: aluCtrl = ALU_ADD;
      ALUOP_SUB: aluCtrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  aluCtrl = ALU_ADD;
          FN_SUB:  aluCtrl = ALU_SUB;
          FN_AND:  aluCtrl = ALU_AND;
          FN_OR:   aluCtrl = ALU_OR;
          FN_SLT:  aluCtrl = ALU_SLT;
          FN_NOR:  aluCtrl = ALU_NOR;
          default: aluCtrl = ALU_NOP;
        endcase
      end
      ALUOP_IMM: begin
        case (opcode)
          OP_ADDI: aluCtrl = ALU_ADD;
          OP_ANDI: aluCtrl = ALU_AND;
          OP_ORI:  aluCtrl = ALU_OR;
          OP_SLTI: aluCtrl = ALU_SLT;
          default: aluCtrl = ALU_NOP;
        endcase
      end
      default: aluCtrl = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register and ALU operand selection.
//   clk, rstN           : clock, synchronous active-low reset
//   idValid/stall/flush : stage control (reset > flush > stall > load)
//   id*                 : decoded ID fields captured into the stage register
//   mem*/wb*            : EX/MEM and MEM/WB write-back info for forwarding
//   aluCtrl             : registered ALU control code
//   inA/inB/exStoreData : forwarded operands (combinational from stage register)
//   exDestReg, exValid, exRegWrite, exMemRead, exMemWrite : registered controls
//   loadUseStall        : load-use hazard request back to ID/IF
module ex_operand_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rstN,
  input  logic        idValid,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  idAluOp,
  input  logic [5:0]  idOpcode,
  input  logic [5:0]  idFunct,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic [4:0]  idRd,
  input  logic        idRegDst,
  input  logic        idAluSrc,
  input  logic        idRegWrite,
  input  logic        idMemRead,
  input  logic        idMemWrite,
  input  logic [31:0] idRsData,
  input  logic [31:0] idRtData,
  input  logic [15:0] idImm16,
  input  logic        memRegWrite,
  input  logic [4:0]  memRd,
  input  logic [31:0] memResult,
  input  logic        wbRegWrite,
  input  logic [4:0]  wbRd,
  input  logic [31:0] wbResult,
  output logic [3:0]  aluCtrl,
  output logic [31:0] inA,
  output logic [31:0] inB,
  output logic [31:0] exStoreData,
  output logic [4:0]  exDestReg,
  output logic        exValid,
  output logic        exRegWrite,
  output logic        exMemRead,
  output logic        exMemWrite,
  output logic        loadUseStall
);

  ex_reg_t     q;
  ex_reg_t     d;
  logic [3:0]  dec_ctrl;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  alu_ctrl_decode u_dec (
    .aluOp  (idAluOp),
    .opcode (idOpcode),
    .funct  (idFunct),
    .aluCtrl(dec_ctrl)
  );

  always_comb begin
    d           = '0;
    d.valid     = idValid;
    d.reg_write = idRegWrite;
    d.mem_read  = idMemRead;
    d.mem_write = idMemWrite;
    d.reg_dst   = idRegDst;
    d.alu_src   = idAluSrc;
    d.alu_ctrl  = dec_ctrl;
    d.rs        = idRs;
    d.rt        = idRt;
    d.rd        = idRd;
    d.rs_data   = idRsData;
    d.rt_data   = idRtData;
    d.imm       = imm_extend(idOpcode, idImm16);
  end

  // Flush clears only valid and control; data fields are don't-care in a bubble.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      q <= '0;
    end else if (flush) begin
      q.valid     <= 1'b0;
      q.reg_write <= 1'b0;
      q.mem_read  <= 1'b0;
      q.mem_write <= 1'b0;
      q.reg_dst   <= 1'b0;
      q.alu_src   <= 1'b0;
      q.alu_ctrl  <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

  // EX/MEM is the younger result, so it beats MEM/WB; r0 is never forwarded.
  function automatic logic [31:0] forward(
    input logic [4:0]  r,
    input logic [31:0] reg_val,
    input logic        m_we,
    input logic [4:0]  m_rd,
    input logic [31:0] m_res,
    input logic        w_we,
    input logic [4:0]  w_rd,
    input logic [31:0] w_res
  );
    if (m_we && m_rd != 5'd0 && m_rd == r) return m_res;
    if (w_we && w_rd != 5'd0 && w_rd == r) return w_res;
    return reg_val;
  endfunction

  assign fwd_a = forward(q.rs, q.rs_data, memRegWrite, memRd, memResult, wbRegWrite, wbRd, wbResult);
  assign fwd_b = forward(q.rt, q.rt_data, memRegWrite, memRd, memResult, wbRegWrite, wbRd, wbResult);

  assign inA         = fwd_a;
  assign inB         = q.alu_src ? q.imm : fwd_b;
  assign exStoreData = fwd_b;
  assign aluCtrl     = q.alu_ctrl;
  assign exDestReg   = q.reg_dst ? q.rd : q.rt;
  assign exValid     = q.valid;
  assign exRegWrite  = q.valid & q.reg_write;
  assign exMemRead   = q.valid & q.mem_read;
  assign exMemWrite  = q.valid & q.mem_write;

  assign loadUseStall = exMemRead && (exDestReg != 5'd0) &&
                        ((exDestReg == idRs) || (exDestReg == idRt));

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rstN, idValid, stall, flush;
  logic [1:0]  idAluOp;
  logic [5:0]  idOpcode, idFunct;
  logic [4:0]  idRs, idRt, idRd;
  logic        idRegDst, idAluSrc, idRegWrite, idMemRead, idMemWrite;
  logic [31:0] idRsData, idRtData;
  logic [15:0] idImm16;
  logic        memRegWrite, wbRegWrite;
  logic [4:0]  memRd, wbRd;
  logic [31:0] memResult, wbResult;
  logic [3:0]  aluCtrl;
  logic [31:0] inA, inB, exStoreData;
  logic [4:0]  exDestReg;
  logic        exValid, exRegWrite, exMemRead, exMemWrite, loadUseStall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rstN(rstN), .idValid(idValid), .stall(stall), .flush(flush),
    .idAluOp(idAluOp), .idOpcode(idOpcode), .idFunct(idFunct),
    .idRs(idRs), .idRt(idRt), .idRd(idRd),
    .idRegDst(idRegDst), .idAluSrc(idAluSrc),
    .idRegWrite(idRegWrite), .idMemRead(idMemRead), .idMemWrite(idMemWrite),
    .idRsData(idRsData), .idRtData(idRtData), .idImm16(idImm16),
    .memRegWrite(memRegWrite), .memRd(memRd), .memResult(memResult),
    .wbRegWrite(wbRegWrite), .wbRd(wbRd), .wbResult(wbResult),
    .aluCtrl(aluCtrl), .inA(inA), .inB(inB), .exStoreData(exStoreData),
    .exDestReg(exDestReg), .exValid(exValid), .exRegWrite(exRegWrite),
    .exMemRead(exMemRead), .exMemWrite(exMemWrite), .loadUseStall(loadUseStall)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_id(input logic [1:0] aop, input logic [5:0] opc, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic rdst, input logic asrc, input logic rw, input logic mr,
                        input logic mw, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [15:0] imm);
    idValid = 1'b1; idAluOp = aop; idOpcode = opc; idFunct = fn;
    idRs = rs; idRt = rt; idRd = rd; idRegDst = rdst; idAluSrc = asrc;
    idRegWrite = rw; idMemRead = mr; idMemWrite = mw;
    idRsData = rsd; idRtData = rtd; idImm16 = imm;
  endtask

  task automatic no_fwd();
    memRegWrite = 0; memRd = 0; memResult = 0; wbRegWrite = 0; wbRd = 0; wbResult = 0;
  endtask

  task automatic test_reset();
    // load something non-zero first, then reset while stall and flush are also up
    set_id(2'b10, 6'd0, 6'b100000, 5'd1, 5'd2, 5'd3, 1, 0, 1, 1, 1, 32'h55, 32'h66, 16'h0);
    tick();
    rstN = 0; stall = 1; flush = 1;
    tick();
    checks++; if (aluCtrl !== 4'b0000) begin errors++; $display("FAIL reset_aluCtrl got %h exp 0", aluCtrl); end
    checks++; if ({exValid, exRegWrite, exMemRead, exMemWrite} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got %b exp 0000", {exValid, exRegWrite, exMemRead, exMemWrite}); end
    checks++; if (exDestReg !== 5'd0) begin errors++; $display("FAIL reset_dest got %0d exp 0", exDestReg); end
    checks++; if ({inA, inB, exStoreData} !== 96'd0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", inA, inB, exStoreData); end
    checks++; if (loadUseStall !== 1'b0) begin errors++; $display("FAIL reset_lus got %b exp 0", loadUseStall); end
    rstN = 1; stall = 0; flush = 0;
    set_id(2'b10, 6'd0, 6'b100000, 5'd1, 5'd2, 5'd3, 1, 0, 1, 0, 0, 32'd5, 32'd7, 16'h0);
    tick();
    checks++; if (aluCtrl !== 4'b0010) begin errors++; $display("FAIL radd_aluCtrl got %b exp 0010", aluCtrl); end
    checks++; if (inA !== 32'd5) begin errors++; $display("FAIL radd_inA got %0d exp 5", inA); end
    checks++; if (inB !== 32'd7) begin errors++; $display("FAIL radd_inB got %0d exp 7", inB); end
    checks++; if ({exValid, exRegWrite, exDestReg} !== {2'b11, 5'd3}) begin errors++; $display("FAIL radd_ctrl got %b %b %0d exp 1 1 3", exValid, exRegWrite, exDestReg); end
  endtask

  task automatic test_forward();
    set_id(2'b10, 6'd0, 6'b100000, 5'd3, 5'd5, 5'd6, 1, 0, 1, 0, 0, 32'h11, 32'h22, 16'h0);
    tick();
    memRegWrite = 1; memRd = 3; memResult = 32'hAA; wbRegWrite = 1; wbRd = 3; wbResult = 32'hBB;
    #1;
    checks++; if (inA !== 32'hAA) begin errors++; $display("FAIL fwd_mem_prio got %h exp aa", inA); end
    checks++; if (inB !== 32'h22) begin errors++; $display("FAIL fwd_b_none got %h exp 22", inB); end
    memRegWrite = 0; #1;
    checks++; if (inA !== 32'hBB) begin errors++; $display("FAIL fwd_wb got %h exp bb", inA); end
    wbRegWrite = 0; #1;
    checks++; if (inA !== 32'h11) begin errors++; $display("FAIL fwd_none got %h exp 11", inA); end
    memRegWrite = 1; memRd = 5; memResult = 32'hCC; #1;
    checks++; if ({inB, exStoreData} !== {32'hCC, 32'hCC}) begin errors++; $display("FAIL fwd_b_mem got %h %h exp cc cc", inB, exStoreData); end
    no_fwd();
    set_id(2'b10, 6'd0, 6'b100000, 5'd0, 5'd0, 5'd6, 1, 0, 1, 0, 0, 32'h33, 32'h44, 16'h0);
    tick();
    memRegWrite = 1; memRd = 0; memResult = 32'hAA; wbRegWrite = 1; wbRd = 0; wbResult = 32'hBB; #1;
    checks++; if ({inA, inB} !== {32'h33, 32'h44}) begin errors++; $display("FAIL fwd_r0 got %h %h exp 33 44", inA, inB); end
    no_fwd();
  endtask

  task automatic test_imm();
    set_id(2'b11, 6'b001101, 6'd0, 5'd1, 5'd2, 5'd0, 0, 1, 1, 0, 0, 32'd9, 32'd9, 16'h8001);
    tick();
    checks++; if (inB !== 32'h00008001) begin errors++; $display("FAIL ori_inB got %h exp 00008001", inB); end
    checks++; if (aluCtrl !== 4'b0001) begin errors++; $display("FAIL ori_ctrl got %b exp 0001", aluCtrl); end
    checks++; if (exDestReg !== 5'd2) begin errors++; $display("FAIL ori_dest got %0d exp 2", exDestReg); end
    set_id(2'b11, 6'b001000, 6'd0, 5'd1, 5'd2, 5'd0, 0, 1, 1, 0, 0, 32'd9, 32'd9, 16'h8001);
    tick();
    checks++; if (inB !== 32'hFFFF8001) begin errors++; $display("FAIL addi_inB got %h exp ffff8001", inB); end
    checks++; if (aluCtrl !== 4'b0010) begin errors++; $display("FAIL addi_ctrl got %b exp 0010", aluCtrl); end
    set_id(2'b11, 6'b001100, 6'd0, 5'd1, 5'd2, 5'd0, 0, 1, 1, 0, 0, 32'd9, 32'd9, 16'hF00F);
    tick();
    checks++; if ({aluCtrl, inB} !== {4'b0000, 32'h0000F00F}) begin errors++; $display("FAIL andi got %b %h exp 0000 0000f00f", aluCtrl, inB); end
    set_id(2'b11, 6'b001010, 6'd0, 5'd1, 5'd2, 5'd0, 0, 1, 1, 0, 0, 32'd9, 32'd9, 16'hFFFE);
    tick();
    checks++; if ({aluCtrl, inB} !== {4'b0111, 32'hFFFFFFFE}) begin errors++; $display("FAIL slti got %b %h exp 0111 fffffffe", aluCtrl, inB); end
    set_id(2'b11, 6'b111111, 6'd0, 5'd1, 5'd2, 5'd0, 0, 1, 1, 0, 0, 32'd9, 32'd9, 16'h0);
    tick();
    checks++; if (aluCtrl !== 4'b1111) begin errors++; $display("FAIL imm_unknown got %b exp 1111", aluCtrl); end
    set_id(2'b01, 6'b000100, 6'd0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0, 0, 32'd9, 32'd9, 16'h0);
    tick();
    checks++; if (aluCtrl !== 4'b0110) begin errors++; $display("FAIL aluop_sub got %b exp 0110", aluCtrl); end
  endtask

  task automatic test_load_use();
    set_id(2'b00, 6'b100011, 6'd0, 5'd1, 5'd4, 5'd0, 0, 1, 1, 1, 0, 32'h100, 32'h0, 16'h0008);
    tick();
    checks++; if ({exMemRead, exDestReg, inB} !== {1'b1, 5'd4, 32'h8}) begin errors++; $display("FAIL lw_latch got %b %0d %h exp 1 4 8", exMemRead, exDestReg, inB); end
    set_id(2'b10, 6'd0, 6'b100000, 5'd5, 5'd6, 5'd7, 1, 0, 1, 0, 0, 32'h0, 32'h0, 16'h0);
    #1;
    checks++; if (loadUseStall !== 1'b0) begin errors++; $display("FAIL lus_nodep got %b exp 0", loadUseStall); end
    idRs = 4; #1;
    checks++; if (loadUseStall !== 1'b1) begin errors++; $display("FAIL lus_rs got %b exp 1", loadUseStall); end
    idRs = 5; idRt = 4; #1;
    checks++; if (loadUseStall !== 1'b1) begin errors++; $display("FAIL lus_rt got %b exp 1", loadUseStall); end
    flush = 1;
    tick();
    flush = 0;
    checks++; if ({exValid, exRegWrite, exMemRead, exMemWrite} !== 4'b0000) begin errors++; $display("FAIL lus_flush_ctrl got %b exp 0000", {exValid, exRegWrite, exMemRead, exMemWrite}); end
    checks++; if ({aluCtrl, loadUseStall} !== 5'b0) begin errors++; $display("FAIL lus_flush_alu got %b %b exp 0000 0", aluCtrl, loadUseStall); end
    // sw: store data is the forwarded rt, memWrite is visible
    set_id(2'b00, 6'b101011, 6'd0, 5'd1, 5'd8, 5'd0, 0, 1, 0, 0, 1, 32'h200, 32'h1234, 16'h0004);
    tick();
    wbRegWrite = 1; wbRd = 8; wbResult = 32'h5678; #1;
    checks++; if ({exMemWrite, exStoreData, inB} !== {1'b1, 32'h5678, 32'h4}) begin errors++; $display("FAIL sw got %b %h %h exp 1 5678 4", exMemWrite, exStoreData, inB); end
    no_fwd();
  endtask

  task automatic test_stall_flush();
    set_id(2'b10, 6'd0, 6'b100010, 5'd1, 5'd2, 5'd9, 1, 0, 1, 0, 0, 32'd10, 32'd3, 16'h0);
    tick();
    checks++; if ({aluCtrl, exDestReg} !== {4'b0110, 5'd9}) begin errors++; $display("FAIL sub_load got %b %0d exp 0110 9", aluCtrl, exDestReg); end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(2'b10, 6'd0, 6'b100100, 5'd11 + 5'(i), 5'd12, 5'd13, 0, 1, 0, 1, 1, 32'hDEAD, 32'hBEEF, 16'h7);
      tick();
      checks++; if ({aluCtrl, exDestReg, inA, inB, exValid, exRegWrite, exMemRead} !== {4'b0110, 5'd9, 32'd10, 32'd3, 3'b110}) begin errors++; $display("FAIL stall_hold%0d got %b %0d %0d %0d %b%b%b", i, aluCtrl, exDestReg, inA, inB, exValid, exRegWrite, exMemRead); end
    end
    // result arriving during the stall is picked up by the held instruction
    wbRegWrite = 1; wbRd = 1; wbResult = 32'h77; #1;
    checks++; if (inA !== 32'h77) begin errors++; $display("FAIL stall_fwd got %h exp 77", inA); end
    no_fwd();
    flush = 1;
    tick();
    stall = 0; flush = 0;
    checks++; if ({exValid, exRegWrite, aluCtrl} !== 6'b0) begin errors++; $display("FAIL stall_flush got %b %b %b exp 0 0 0000", exValid, exRegWrite, aluCtrl); end
    set_id(2'b10, 6'd0, 6'b111111, 5'd1, 5'd2, 5'd3, 1, 0, 1, 0, 0, 32'd1, 32'd1, 16'h0);
    tick();
    checks++; if (aluCtrl !== 4'b1111) begin errors++; $display("FAIL funct_unknown got %b exp 1111", aluCtrl); end
    idValid = 0;
    tick();
    checks++; if ({exValid, exRegWrite} !== 2'b00) begin errors++; $display("FAIL invalid_gate got %b%b exp 00", exValid, exRegWrite); end
  endtask

  task automatic test_back_to_back();
    set_id(2'b10, 6'd0, 6'b100111, 5'd1, 5'd2, 5'd3, 1, 0, 1, 0, 0, 32'd1, 32'd2, 16'h0);
    tick();
    checks++; if (aluCtrl !== 4'b1100) begin errors++; $display("FAIL b2b_nor got %b exp 1100", aluCtrl); end
    set_id(2'b10, 6'd0, 6'b101010, 5'd4, 5'd5, 5'd6, 1, 0, 1, 0, 0, 32'd8, 32'd9, 16'h0);
    tick();
    checks++; if ({aluCtrl, inA, inB, exDestReg} !== {4'b0111, 32'd8, 32'd9, 5'd6}) begin errors++; $display("FAIL b2b_slt got %b %0d %0d %0d", aluCtrl, inA, inB, exDestReg); end
    set_id(2'b10, 6'd0, 6'b100101, 5'd7, 5'd8, 5'd10, 1, 0, 1, 0, 0, 32'd3, 32'd4, 16'h0);
    tick();
    checks++; if ({aluCtrl, inA, exDestReg} !== {4'b0001, 32'd3, 5'd10}) begin errors++; $display("FAIL b2b_or got %b %0d %0d", aluCtrl, inA, exDestReg); end
  endtask

  initial begin
    rstN = 0; stall = 0; flush = 0;
    set_id(2'b00, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 16'h0);
    idValid = 0;
    no_fwd();
    tick(); tick();
    rstN = 1;
    test_reset();
    test_forward();
    test_imm();
    test_load_use();
    test_stall_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage of the five-stage MIPS core, directly upstream of the ALU. It latches decoded ID-stage fields on each clock, translates ALUOp/opcode/funct into the 4-bit ALU control code, and drives the ALU operand inputs. Operands come from forwarding muxes fed by the EX/MEM and MEM/WB results. It also handles pipeline stall and flush, and raises the load-use hazard request back to ID.

## Interface
Parameters: none; widths are fixed by the ISA.

Ports:
- clk  in  1  core clock, rising edge
- rstN  in  1  reset; synchronous, active-low
- idValid  in  1  ID holds a real instruction
- stall  in  1  hold all stage registers
- flush  in  1  load a bubble
- idAluOp  in  2  00 add, 01 sub, 10 R-type (funct), 11 immediate (opcode)
- idOpcode  in  6  instruction [31:26]
- idFunct  in  6  instruction [5:0]
- idRs, idRt, idRd  in  5 each  register specifiers
- idRegDst  in  1  1: destination is rd, 0: destination is rt
- idAluSrc  in  1  1: inB is the extended immediate
- idRegWrite, idMemRead, idMemWrite  in  1 each  control bits
- idRsData, idRtData  in  32 each  register-file read data
- idImm16  in  16  immediate field
- memRegWrite  in  1  EX/MEM instruction writes a register
- memRd  in  5  EX/MEM destination register
- memResult  in  32  EX/MEM result
- wbRegWrite  in  1  MEM/WB instruction writes a register
- wbRd  in  5  MEM/WB destination register
- wbResult  in  32  MEM/WB result
- aluCtrl  out  4  to ALU, registered
- inA, inB  out  32 each  to ALU, combinational from registered state and forwarding inputs
- exStoreData  out  32  forwarded rt value, for sw
- exDestReg  out  5  selected destination register
- exValid, exRegWrite, exMemRead, exMemWrite  out  1 each  registered, gated by valid
- loadUseStall  out  1  stall request to ID/IF

## Operation
- Register update priority: reset > flush > stall > load.
  - Flush: valid and all control bits go to 0; the data fields may hold stale values.
  - Stall: every register holds its value.
  - Load: capture all id* fields and the decoded aluCtrl; exValid = idValid.
- aluCtrl decode, performed at capture time. Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
  - AluOp 00 gives 0010. AluOp 01 gives 0110.
  - AluOp 10 (funct): 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111, 100111→1100, any other→1111 (ALU outputs 0).
  - AluOp 11 (opcode): 001000 addi→0010, 001100 andi→0000, 001101 ori→0001, 001010 slti→0111, any other→1111.
- Immediate extension: zero-extend for opcodes 001100 and 001101; sign-extend otherwise.
- Forwarding for operand A (rs), and identically for B-source (rt):
  - If memRegWrite and memRd≠0 and memRd==rs, take memResult.
  - Else if wbRegWrite and wbRd≠0 and wbRd==rs, take wbResult.
  - Else take the latched register data.
  - Register 0 is never forwarded.
- inB = extended immediate when aluSrc=1, otherwise the forwarded rt value. exStoreData is always the forwarded rt value.
- exDestReg = rd if regDst=1, otherwise rt.
- loadUseStall = exValid & exMemRead & (exDestReg≠0) & (exDestReg==idRs | exDestReg==idRt). Purely combinational.

## Timing
- Reset (rstN=0 at a clock edge): every register goes to 0. Outputs afterwards: aluCtrl=0000, exValid/exRegWrite/exMemRead/exMemWrite=0, exDestReg=0, inA=inB=exStoreData=0 (rs=rt=0 means no forwarding).
- Reset asserted while stalled or flushing wins unconditionally.
- Latency: one cycle from ID inputs to aluCtrl and the control outputs.
- inA/inB follow the forwarding inputs within the same cycle; there is no added register stage.
- stall and flush asserted in the same cycle: flush wins.
- A stalled instruction re-evaluates forwarding every cycle, so a result arriving during the stall is picked up.
- loadUseStall lasts one cycle per load-use pair. ID is responsible for asserting stall to ID and flush to this stage.

## Structure
- Shared package `mips_pkg` holds:
  - ALU control codes: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_NOP=1111.
  - ALUOp encodings.
  - Opcode and funct constants.
- One sub-module is natural: `alu_ctrl_decode`, combinational, taking aluOp, opcode and funct and returning aluCtrl. It is reused by verification.
- Forwarding muxes and the pipeline register stay in this module.

## Test plan
- Reset mid-stream, then release:
  - All outputs are 0 on the following cycle.
  - An R-type add (funct 100000, rs data 5, rt data 7) captured one cycle later gives aluCtrl=0010, inA=5, inB=7.
- Forward priority:
  - With rs=3 and both memRd=3 and wbRd=3 writing (memResult=0xAA, wbResult=0xBB): inA=0xAA.
  - With memRegWrite=0: inA=0xBB.
  - With rs=0 and memRd=0: inA equals the latched data, no forwarding.
- Immediate extension:
  - ori with imm 0x8001 gives inB=0x00008001, aluCtrl=0001.
  - addi with imm 0x8001 gives inB=0xFFFF8001, aluCtrl=0010.
- Load-use:
  - lw to rt=4 latched (exMemRead=1), then idRs=4: loadUseStall=1.
  - Apply stall=0 and flush=1: next cycle exValid=0 and all control outputs are 0.
- Stall and flush combinations:
  - stall=1 for 3 cycles with ID inputs changing: outputs hold.
  - stall=1 and flush=1 together: bubble.
  - Unknown funct 111111: aluCtrl=1111.
